fir_capture_buffer: RTL and testbench

//   Sink at the output end of fir_filter: arms on command, captures DEPTH consecutive valid
//   y_out samples into on-chip RAM, then drains them to a downstream consumer over a

---
 rtl/fir_capture_buffer_pkg.sv | 11 +
 rtl/fir_capture_buffer_ram.sv | 27 ++
 rtl/fir_capture_buffer.sv | 155 +++++++++++++++
 tb/tb_fir_capture_buffer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_capture_buffer_pkg.sv
// rtl/fir_capture_buffer_pkg.sv - shared sample width and FSM state encodings for the capture buffer
package fir_capture_buffer_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

endpackage

// File: rtl/fir_capture_buffer_ram.sv
// rtl/fir_capture_buffer_ram.sv - simple dual-port sample RAM, sync write, 1-cycle sync read
module fir_cap_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fir_capture_buffer.sv
// rtl/fir_capture_buffer.sv - arm/capture/drain buffer for fir_filter output samples
// Optional level trigger enabled by defining FIR_CAP_TRIG_EN.
module fir_capture_buffer
    import fir_capture_buffer_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   fill_count
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   rd_cnt;
    logic              pf_valid;
    logic              pf_last;
    logic [DATA_W-1:0] rd_data;

    logic trigger;
    logic handshake;
    logic load_out;
    logic final_sample;
    logic ram_we;
    logic ram_re;

`ifdef FIR_CAP_TRIG_EN
    assign trigger = sample_valid && ($signed(sample_in) >= $signed(trig_level));
`else
    logic unused_trig_level;
    assign unused_trig_level = ^trig_level;
    assign trigger = sample_valid;
`endif

    assign handshake    = out_valid && out_ready;
    assign load_out     = (state == ST_DRAIN) && pf_valid && (!out_valid || out_ready);
    assign final_sample = (state == ST_CAPTURE) && sample_valid && (fill_count == CNT_LAST);
    assign ram_we       = !abort && (((state == ST_ARMED) && trigger) ||
                                     ((state == ST_CAPTURE) && sample_valid));
    // Word 0 is fetched on the final capture edge so out_valid can rise right after done.
    assign ram_re       = final_sample ||
                          ((state == ST_DRAIN) && (rd_cnt < CNT_FULL) && (!pf_valid || load_out));
    assign busy         = (state != ST_IDLE);

    fir_cap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (sample_in),
        .re    (ram_re),
        .raddr (rd_cnt[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_cnt     <= '0;
            pf_valid   <= 1'b0;
            pf_last    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            fill_count <= '0;
        end else begin
            done <= 1'b0;

            if (ram_re) begin
                rd_cnt   <= rd_cnt + (ADDR_W+1)'(1);
                pf_valid <= 1'b1;
                pf_last  <= (rd_cnt == CNT_LAST);
            end else if (load_out) begin
                pf_valid <= 1'b0;
            end

            if (load_out) begin
                out_data  <= rd_data;
                out_last  <= pf_last;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state      <= ST_ARMED;
                        wr_ptr     <= '0;
                        rd_cnt     <= '0;
                        fill_count <= '0;
                    end
                end
                ST_ARMED: begin
                    if (trigger) begin
                        state      <= ST_CAPTURE;
                        wr_ptr     <= ADDR_W'(1);
                        fill_count <= (ADDR_W+1)'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        wr_ptr     <= wr_ptr + ADDR_W'(1);
                        fill_count <= fill_count + (ADDR_W+1)'(1);
                        if (final_sample) begin
                            state <= ST_DRAIN;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (handshake && out_last) begin
                        state      <= ST_IDLE;
                        fill_count <= '0;
                        rd_cnt     <= '0;
                        pf_valid   <= 1'b0;
                    end
                end
            endcase

            if (abort) begin
                state      <= ST_IDLE;
                fill_count <= '0;
                rd_cnt     <= '0;
                pf_valid   <= 1'b0;
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                done       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_capture_buffer.sv
// tb/tb_fir_capture_buffer.sv - self-checking bench for fir_capture_buffer
module tb_fir_capture_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              abort;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   fill_count;

    always #5 clk = ~clk;

    fir_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .abort        (abort),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .fill_count   (fill_count)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   stored;
    bit   trig_seen;
    int   lvl;
    int   ready_mode = 0;
    int   rcyc = 0;

    int   cyc = 0;
    int   hs_cnt, done_cnt, first_cyc, last_cyc, first_word, last_word;
    bit   done_prev, stall_prev;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Trigger rule in plain arithmetic on the integer sample value.
    function automatic bit fires(input int v);
`ifdef FIR_CAP_TRIG_EN
        return v >= lvl;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                done_prev  = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (done_prev) check("done_to_valid", out_valid, 1);
                if (done) begin
                    done_cnt++;
                    check("valid_with_done", out_valid, 0);
                end
                done_prev = done;
                if (stall_prev) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got %0d expected no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", out_data, e.d);
                        check("word_last", out_last, e.l);
                    end
                    if (hs_cnt == 0) begin
                        first_cyc  = cyc;
                        first_word = int'($signed(out_data));
                    end
                    last_cyc  = cyc;
                    last_word = int'($signed(out_data));
                    hs_cnt++;
                end
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : (rcyc % 3 == 0);
        rcyc++;
    end

    task automatic start_capture();
        hs_cnt    = 0;
        done_cnt  = 0;
        trig_seen = 1'b0;
        stored    = 0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic feed(input int start, input int step, input bit gaps, input int stop_at);
        int v;
        int guard;
        bit st;
        v = start;
        guard = 0;
        while (stored < stop_at && guard < 200) begin
            st = 1'b0;
            sample_valid = 1'b1;
            sample_in    = v[DATA_W-1:0];
            if (!trig_seen && fires(v)) trig_seen = 1'b1;
            if (trig_seen) begin
                stored++;
                exp_q.push_back('{d: v[DATA_W-1:0], l: (stored == DEPTH)});
                st = 1'b1;
            end
            tick();
            sample_valid = 1'b0;
            if (trig_seen) check("fill_count", fill_count, stored);
            if (st && stored == DEPTH) check("done_on_last_sample", done, 1);
            v += step;
            if (gaps && stored < stop_at) begin
                sample_in = 16'hdead;
                tick();
                if (trig_seen) check("fill_hold_on_gap", fill_count, stored);
            end
            guard++;
        end
        check("feed_bound", stored, stop_at);
    endtask

    task automatic wait_drain(input int words);
        int g;
        g = 0;
        while ((exp_q.size() > 0 || out_valid || busy) && g < 500) begin
            tick();
            g++;
        end
        check("drain_in_time", g < 500, 1);
        check("drain_words", hs_cnt, words);
        check("drain_done_once", done_cnt, 1);
        check("idle_fill", fill_count, 0);
        check("idle_last", out_last, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fill"}, fill_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int seen_valid;
        rst = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        sample_in = '0;
        sample_valid = 1'b0;
        lvl = -32768;
        trig_level = 16'h8000;
        fork
            monitor();
        join_none
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // 1: contiguous capture, full-rate drain
        start_capture();
        feed(10, 10, 1'b0, DEPTH);
        wait_drain(DEPTH);
        check("t1_first_word", first_word, 10);
        check("t1_last_word", last_word, 320);
        check("t1_consecutive", last_cyc - first_cyc, DEPTH - 1);

        // 2: same capture, consumer stalls 1,0,0 pattern
        ready_mode = 1;
        start_capture();
        feed(10, 10, 1'b0, DEPTH);
        wait_drain(DEPTH);
        check("t2_first_word", first_word, 10);
        check("t2_last_word", last_word, 320);
        ready_mode = 0;

        // 3: sample_valid every other cycle, signed values
        start_capture();
        feed(-100, 7, 1'b1, DEPTH);
        wait_drain(DEPTH);
        check("t3_first_word", first_word, -100);
        check("t3_last_word", last_word, -100 + 7 * (DEPTH - 1));

        // 4: abort after five stored samples
        start_capture();
        feed(1, 1, 1'b0, 5);
        check("t4_fill_before_abort", fill_count, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("t4_busy", busy, 0);
        check("t4_fill", fill_count, 0);
        check("t4_out_valid", out_valid, 0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            sample_valid = 1'b1;
            sample_in = 16'(i);
            tick();
            if (out_valid) seen_valid++;
        end
        sample_valid = 1'b0;
        check("t4_no_out_valid", seen_valid, 0);
        check("t4_no_done", done_cnt, 0);
        check("t4_no_words", hs_cnt, 0);

        // 5: level trigger at 25
        lvl = 25;
        trig_level = 16'd25;
        start_capture();
        feed(10, 10, 1'b0, DEPTH);
        wait_drain(DEPTH);
`ifdef FIR_CAP_TRIG_EN
        check("t5_first_word", first_word, 30);
`else
        check("t5_first_word", first_word, 10);
`endif
        lvl = -32768;
        trig_level = 16'h8000;

        // 6: reset while word 7 is pending, then a clean run
        start_capture();
        feed(1000, -3, 1'b0, DEPTH);
        g = 0;
        while (hs_cnt < 7 && g < 100) begin
            tick();
            g++;
        end
        check("t6_reach_word7", hs_cnt, 7);
        rst = 1'b1;
        tick();
        check_reset_outputs("t6_reset");
        rst = 1'b0;
        exp_q.delete();
        tick();
        start_capture();
        feed(-5, 11, 1'b0, DEPTH);
        wait_drain(DEPTH);
        check("t6_first_word", first_word, -5);
        check("t6_last_word", last_word, -5 + 11 * (DEPTH - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
